// File: rtl/dot_accumulator_pkg.sv
// dot_accumulator_pkg: shared FSM state type and saturation limits for the dot-product accumulator
package dot_accumulator_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;
endpackage

// File: rtl/dot_accumulator_if.sv
// dot_accumulator_if: job control, product input and result output handshakes of the accumulator
interface dot_accumulator_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic             busy;
  modport master (
    output start, len, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );
  modport slave (
    input  start, len, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/dot_accumulator_acc_add.sv
// acc_add: combinational signed adder with overflow bit; clamps instead of wrapping when DOT_ACCUMULATOR_SAT_EN is defined
module acc_add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  logic [WIDTH-1:0] raw;
  assign raw = a + b;
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
`ifdef DOT_ACCUMULATOR_SAT_EN
  // on overflow both operands share a's sign, so that sign picks the clamp direction
  assign sum = ovf ? {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}} : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/dot_accumulator.sv
// dot_accumulator: sums len signed products into one result with sticky overflow; saturating when DOT_ACCUMULATOR_SAT_EN is defined
module dot_accumulator
  import dot_accumulator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 4
) (
  input logic clk,
  input logic rst,
  dot_accumulator_if.slave bus
);
  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n, add_sum;
  logic [LEN_W-1:0] rem, rem_n;
  logic             ovf, ovf_n, add_ovf;
  acc_add #(.WIDTH(WIDTH)) u_add (
    .a  (acc),
    .b  (bus.in_prod),
    .sum(add_sum),
    .ovf(add_ovf)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      rem   <= rem_n;
      ovf   <= ovf_n;
    end
  end
  always_comb begin
    state_n = state;
    acc_n   = acc;
    rem_n   = rem;
    ovf_n   = ovf;
    case (state)
      IDLE: if (bus.start) begin
        state_n = (bus.len == '0) ? HOLD : ACC;
        acc_n   = '0;
        rem_n   = bus.len;
        ovf_n   = 1'b0;
      end
      ACC: if (bus.in_valid) begin
        acc_n   = add_sum;
        rem_n   = rem - LEN_W'(1);
        ovf_n   = ovf | add_ovf;
        state_n = (rem == LEN_W'(1)) ? HOLD : ACC;
      end
      HOLD: state_n = bus.out_ready ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state != IDLE);
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;
endmodule

// File: doc/dot_accumulator.md
# dot_accumulator

Sequential signed accumulator that sits directly downstream of the 16-bit Booth multiplier. It sums a job of `len` products, truncated to 16 bits, into one 16-bit dot-product result. Products arrive through a valid/ready handshake, and the result leaves through a second valid/ready handshake. A sticky overflow flag reports signed overflow for each job.

## Interface
Parameters:
- `WIDTH`, default 16: width of product, accumulator and result.
- `LEN_W`, default 4: width of the term-count field; a job holds at most 2^LEN_W−1 terms.

Ports:
- `clk`  input  1  the only clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  job request; sampled only in IDLE.
- `len`  input  LEN_W  number of products in the job; sampled together with `start`.
- `in_valid`  input  1  `in_prod` is valid.
- `in_ready`  output  1  block accepts a product this cycle.
- `in_prod`  input  WIDTH  product from the multiplier, two's complement.
- `out_valid`  output  1  `out_sum` and `out_ovf` are valid.
- `out_ready`  input  1  consumer takes the result.
- `out_sum`  output  WIDTH  accumulated result.
- `out_ovf`  output  1  signed overflow happened during the job (sticky).
- `busy`  output  1  the state is not IDLE.

## Operation
- FSM states:
  - IDLE (reset state).
  - ACC: accumulating.
  - HOLD: result presented.
- IDLE → ACC on `start` with `len`≠0.
  - Capture `len` into a remaining-term counter `rem`.
  - Clear the accumulator and the overflow flag.
- IDLE → HOLD on `start` with `len`=0; the result is sum 0 with `out_ovf`=0.
- ACC:
  - `in_ready`=1.
  - On each `in_valid`&`in_ready` transfer:
    - `acc` ← `acc` + `in_prod`.
    - `rem` ← `rem`−1.
    - `ovf` ← `ovf` | signed_overflow(`acc`, `in_prod`).
  - Signed overflow means both operands have the same sign and the sum's sign differs.
  - On the transfer with `rem`=1, go to HOLD.
- HOLD:
  - `out_valid`=1 and `in_ready`=0.
  - `out_sum` and `out_ovf` stay stable until `out_ready`=1.
  - When `out_ready`=1, go to IDLE.
- Arithmetic wraps modulo 2^WIDTH by default, matching the truncated multiplier output.
- `start` is ignored outside IDLE, including in the HOLD cycle where `out_ready`=1.
- `in_valid` in IDLE or HOLD is ignored, and no product is consumed.
- Reset in any state gives next cycle:
  - state IDLE.
  - `acc`=0, `rem`=0, `ovf`=0.
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - `out_sum`=0, `out_ovf`=0.
  - Any in-flight job is discarded.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.
- Reset values: `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `busy`=0.
- `start` at edge k:
  - `busy`=1 and `in_ready`=1 from cycle k+1.
  - With `len`=0, `out_valid`=1 from cycle k+1.
- The last product, accepted at edge m, gives `out_valid`=1 in cycle m+1 with the final sum.
- Minimum job latency is `len`+1 cycles from `start` to `out_valid`.
- Gaps in `in_valid` stretch latency 1:1.
- The result is consumed at the edge where `out_valid`&`out_ready`; `busy`=0 from the next cycle.
- Back-to-back jobs: `start` may be asserted in the first IDLE cycle after consumption.

## Configuration
- `DOT_ACCUMULATOR_SAT_EN` defined:
  - Each addition saturates to 0x7FFF on positive overflow and to 0x8000 on negative overflow.
  - `out_ovf` is still set on any clamp.
- Not defined:
  - Each addition wraps modulo 2^WIDTH.
  - `out_ovf` reports overflow only.

## Structure
- Package `dot_accumulator_pkg`:
  - state enum `{IDLE, ACC, HOLD}`, 2-bit encoding.
  - constants `SAT_POS`=0x7FFF and `SAT_NEG`=0x8000.
- One sub-module, `acc_add`:
  - Combinational WIDTH-bit signed adder.
  - Outputs the sum (wrap or saturate, depending on the macro) and an overflow bit.
  - Instantiated once; FSM, counter and registers live in the top.

## Test plan
- `len`=3, products 2, 3, 4 streamed on consecutive cycles → `out_valid` 4 cycles after `start`, `out_sum`=9, `out_ovf`=0.
- `len`=2, products 0x7FFF, 0x0001:
  - Without macro: `out_sum`=0x8000, `out_ovf`=1.
  - With macro: `out_sum`=0x7FFF, `out_ovf`=1.
- `len`=2, products 0xFFFE (−2), 0x0005 → `out_sum`=0x0003, `out_ovf`=0.
- `len`=0 → `out_valid`=1 the cycle after `start`, `out_sum`=0.
- Back-pressure and ignored inputs:
  - Hold `out_ready`=0 for 5 cycles → `out_sum` stays stable and `in_ready`=0.
  - A `start` pulse during HOLD is ignored.
  - After consumption the block returns to IDLE, and a new job runs correctly.
- Reset mid-job:
  - `len`=4, assert `rst` after 2 products → next cycle IDLE with all outputs 0.
  - A new job `len`=1, product 7 → `out_sum`=7.
